jtcop_obj_scan: RTL and testbench



---
 rtl/jtcop_obj_scan_if.sv | 28 ++
 rtl/jtcop_obj_scan.sv | 173 +++++++++++++++++
 tb/tb_jtcop_obj_scan.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtcop_obj_scan_if.sv
// Draw-request bus between the object table scanner (master) and the object
// draw unit (slave).
//   draw      master->slave  one-cycle request strobe
//   draw_busy slave->master  draw unit busy, rises the cycle after draw
//   tile_id   master->slave  tile code of the requested row
//   veff      master->slave  pixel row inside the tile
//   hflip     master->slave  horizontal flip
//   tile_pal  master->slave  palette
//   hpos      master->slave  object x position
interface jtcop_obj_scan_if;
  logic        draw;
  logic        draw_busy;
  logic [10:0] tile_id;
  logic [3:0]  veff;
  logic        hflip;
  logic [3:0]  tile_pal;
  logic [8:0]  hpos;

  modport master (
    output draw, tile_id, veff, hflip, tile_pal, hpos,
    input  draw_busy
  );

  modport slave (
    input  draw, tile_id, veff, hflip, tile_pal, hpos,
    output draw_busy
  );
endinterface

// File: rtl/jtcop_obj_scan.sv
// Object table scanner. On every line_start it walks the object table and,
// for each enabled object whose vertical extent covers vrender, issues one
// draw request for the 16-px tile row hit by the line. Requests are paced
// with the draw unit's busy handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   line_start   one-cycle pulse, starts/restarts the scan
//   vrender      line being rendered (stable while scanning)
//   tbl_addr     object table address {obj[7:0], word[1:0]}
//   tbl_dout     table data, one-cycle read latency
//   scan_done    high from end of scan until the next line_start
//   req          draw-request bus (master side)
module jtcop_obj_scan #(
  parameter int OBJN = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_start,
  input  logic [8:0]         vrender,
  output logic [9:0]         tbl_addr,
  input  logic [15:0]        tbl_dout,
  output logic               scan_done,
  jtcop_obj_scan_if.master   req
);

  localparam logic [7:0] LAST_OBJ = 8'(OBJN - 1);

  typedef enum logic [3:0] {
    IDLE, W0, CHK, W1, C1, W2, C2, ISSUE, GUARD, BUSY, NEXT
  } state_t;

  state_t      state;
  logic [7:0]  obj;

  logic        draw_r;
  logic [10:0] tile_id_r;
  logic [3:0]  veff_r;
  logic        hflip_r;
  logic [3:0]  tile_pal_r;
  logic [8:0]  hpos_r;

  // Per-object fields captured from w0/w1 while the object is processed
  logic [8:0]  vdiff_l;
  logic [1:0]  h_l;
  logic        vflip_l;
  logic        hflip_l;
  logic [10:0] code_l;

  logic [8:0]  vdiff_now;

  // Vertical distance from the object top, modulo 512 so objects that
  // straddle the bottom of the 9-bit line space wrap onto the top lines.
  function automatic logic [8:0] vdist(input logic [8:0] line, input logic [8:0] y);
    return line - y;
  endfunction

  // Object covers the line when its 16-line tile row index is below the
  // object height in tiles (1, 2, 4 or 8).
  function automatic logic obj_visible(input logic en, input logic [8:0] vdiff,
                                       input logic [1:0] h);
    logic [4:0] rows;
    rows = 5'd1 << h;
    return en && (vdiff[8:4] < rows);
  endfunction

  // Tile row within the object, flipped vertically when requested.
  function automatic logic [2:0] tile_row(input logic [2:0] vsub, input logic [1:0] h,
                                          input logic vflip);
    logic [3:0] rows;
    logic [2:0] mask;
    logic [2:0] r;
    rows = 4'd1 << h;
    mask = 3'(rows - 4'd1);
    r    = vsub & mask;
    return vflip ? (mask - r) : r;
  endfunction

  assign vdiff_now = vdist(vrender, tbl_dout[8:0]);

  assign req.draw     = draw_r;
  assign req.tile_id  = tile_id_r;
  assign req.veff     = veff_r;
  assign req.hflip    = hflip_r;
  assign req.tile_pal = tile_pal_r;
  assign req.hpos     = hpos_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      obj        <= '0;
      tbl_addr   <= '0;
      scan_done  <= 1'b1;
      draw_r     <= 1'b0;
      tile_id_r  <= '0;
      veff_r     <= '0;
      hflip_r    <= 1'b0;
      tile_pal_r <= '0;
      hpos_r     <= '0;
    end else if (line_start) begin
      // Restart from any state. A draw strobe already on the bus this cycle
      // has been seen by the draw unit; its busy period still gates ISSUE.
      state     <= W0;
      obj       <= '0;
      tbl_addr  <= '0;
      scan_done <= 1'b0;
      draw_r    <= 1'b0;
    end else begin
      draw_r <= 1'b0;
      case (state)
        IDLE: ;
        W0:   state <= CHK;
        CHK: begin
          if (obj_visible(tbl_dout[15], vdiff_now, tbl_dout[12:11])) begin
            tbl_addr <= {obj, 2'b01};
            state    <= W1;
          end else begin
            state <= NEXT;
          end
        end
        W1:   state <= C1;
        C1: begin
          tbl_addr <= {obj, 2'b10};
          state    <= W2;
        end
        W2:   state <= C2;
        C2: begin
          tile_id_r  <= code_l + {8'd0, tile_row(vdiff_l[6:4], h_l, vflip_l)};
          veff_r     <= vdiff_l[3:0] ^ {4{vflip_l}};
          hflip_r    <= hflip_l;
          tile_pal_r <= tbl_dout[15:12];
          hpos_r     <= tbl_dout[8:0];
          state      <= ISSUE;
        end
        ISSUE: begin
          if (!req.draw_busy) begin
            draw_r <= 1'b1;
            state  <= GUARD;
          end
        end
        // draw_busy only rises the cycle after draw, so it is not trusted here
        GUARD: state <= BUSY;
        BUSY: begin
          if (!req.draw_busy) state <= NEXT;
        end
        NEXT: begin
          if (obj == LAST_OBJ) begin
            scan_done <= 1'b1;
            state     <= IDLE;
          end else begin
            obj      <= obj + 8'd1;
            tbl_addr <= {obj + 8'd1, 2'b00};
            state    <= W0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data-only captures; always written before use within an object
  always_ff @(posedge clk) begin
    if (state == CHK) begin
      vdiff_l <= vdiff_now;
      h_l     <= tbl_dout[12:11];
      vflip_l <= tbl_dout[14];
      hflip_l <= tbl_dout[13];
    end
    if (state == C1) begin
      code_l <= tbl_dout[10:0];
    end
  end

endmodule

// File: tb/tb_jtcop_obj_scan.sv
module tb_jtcop_obj_scan;
  localparam int OBJN = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  vrender = '0;
  logic [9:0]  tbl_addr;
  logic [15:0] tbl_dout;
  logic        scan_done;

  jtcop_obj_scan_if req ();

  jtcop_obj_scan #(.OBJN(OBJN)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .vrender(vrender),
    .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .scan_done(scan_done),
    .req(req.master)
  );

  always #5 clk = ~clk;

  // Object table RAM with one-cycle read latency
  logic [15:0] mem [1024];
  always @(posedge clk) tbl_dout <= mem[tbl_addr];

  // Draw unit: busy for busy_len cycles starting the cycle after draw
  int   busy_len = 0;
  int   bcnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 0;
    else if (req.draw) bcnt <= busy_len;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign req.draw_busy = (bcnt != 0) || force_busy;

  typedef struct packed {
    logic [10:0] tile;
    logic [3:0]  veff;
    logic        hflip;
    logic [3:0]  pal;
    logic [8:0]  hpos;
  } req_t;

  req_t exp_q[$];
  int   draw_cyc[$];
  int   checks = 0;
  int   passes = 0;
  int   draws = 0;
  int   cycle = 0;
  bit   chk_stable = 1'b1;
  req_t last_exp = '0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: list of requests a scan of the table must produce, in order
  function automatic int model_scan(input int vr);
    int n, rows, y, d, ri, row;
    logic [15:0] w0;
    req_t e;
    n = 0;
    for (int o = 0; o < OBJN; o++) begin
      w0   = mem[o*4];
      rows = 1 << int'(w0[12:11]);
      y    = int'(w0[8:0]);
      d    = (vr - y + 512) % 512;
      if (w0[15] && d < 16 * rows) begin
        ri  = d / 16;
        row = w0[14] ? (rows - 1 - ri) : ri;
        e.tile  = 11'(int'(mem[o*4+1] & 16'h07FF) + row);
        e.veff  = w0[14] ? 4'(15 - d % 16) : 4'(d % 16);
        e.hflip = w0[13];
        e.pal   = mem[o*4+2][15:12];
        e.hpos  = mem[o*4+2][8:0];
        exp_q.push_back(e);
        n++;
      end
    end
    return n;
  endfunction

  // Compare process: every draw strobe against the model, outputs held
  // at the last request while the draw unit is busy with it
  always @(negedge clk) begin
    req_t cur;
    cur = {req.tile_id, req.veff, req.hflip, req.tile_pal, req.hpos};
    if (rst_n) begin
      if (req.draw) begin
        draws++;
        draw_cyc.push_back(cycle);
        check("busy_at_draw", {31'd0, req.draw_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_draw", 32'd1, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          check("draw_fields", cur, last_exp);
        end
      end else if (chk_stable && bcnt != 0) begin
        check("stable_while_busy", cur, last_exp);
      end
    end
  end

  task automatic clear_table();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic start_line(output logic sd, output logic [9:0] ta);
    @(negedge clk);
    line_start = 1'b1;
    @(posedge clk);
    #1;
    sd = scan_done;
    ta = tbl_addr;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk);
      #1;
      if (scan_done) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_scan(input string name, input int vr, input int blen,
                          input bit chk_time, output int cyc);
    int nvis;
    logic sd;
    logic [9:0] ta;
    vrender  = 9'(vr);
    busy_len = blen;
    exp_q.delete();
    nvis = model_scan(vr);
    start_line(sd, ta);
    check({name, "_done_low"}, {31'd0, sd}, 32'd0);
    wait_done(name, 20000, cyc);
    check({name, "_left"}, exp_q.size(), 32'd0);
    if (chk_time)
      check({name, "_cycles"}, cyc, 3 * (OBJN - nvis) + (10 + blen) * nvis);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, cyc, d0, vr;
    logic sd;
    logic [9:0] ta;
    bit   seen;

    clear_table();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_draw", req.draw, 0);
    check("rst_scan_done", scan_done, 1);
    check("rst_outs", {req.tile_id, req.veff, req.hflip, req.tile_pal, req.hpos}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single object, plain
    mem[20] = 16'h8064; mem[21] = 16'h0123; mem[22] = 16'h3050;
    exp_q.delete();
    n = model_scan(107);
    check("model_obj5_n", n, 1);
    if (n > 0) check("model_obj5", exp_q[0], {11'h123, 4'd7, 1'b0, 4'd3, 9'h050});
    d0 = draws;
    run_scan("obj5", 107, 0, 1, cyc);
    check("obj5_draws", draws - d0, 1);
    check("obj5_tile", req.tile_id, 11'h123);
    check("obj5_veff", req.veff, 7);
    check("obj5_pal_hpos", {req.tile_pal, req.hpos}, {4'd3, 9'h050});

    // vflip, 4 tiles tall
    mem[20] = 16'hD064;
    exp_q.delete();
    n = model_scan(137);
    if (n > 0) check("model_vflip", exp_q[0], {11'h124, 4'd10, 1'b0, 4'd3, 9'h050});
    run_scan("vflip", 137, 0, 1, cyc);
    check("vflip_tile", req.tile_id, 11'h124);
    check("vflip_veff", req.veff, 10);

    // Wrap around line 511
    mem[20] = 16'h81FC;
    exp_q.delete();
    n = model_scan(3);
    if (n > 0) check("model_wrap", exp_q[0], {11'h123, 4'd7, 1'b0, 4'd3, 9'h050});
    run_scan("wrap", 3, 0, 1, cyc);
    check("wrap_veff", req.veff, 7);
    exp_q.delete();
    check("model_wrap_miss", model_scan(12), 0);
    d0 = draws;
    run_scan("wrap_miss", 12, 0, 1, cyc);
    check("wrap_miss_draws", draws - d0, 0);

    // Two visible objects, long busy
    mem[20] = 16'h8064;
    mem[36] = 16'hA864; mem[37] = 16'h07FF; mem[38] = 16'hF1FF;
    exp_q.delete();
    n = model_scan(110);
    check("model_two_n", n, 2);
    if (n > 1) check("model_two_b", exp_q[1], {11'h7FF, 4'd10, 1'b1, 4'hF, 9'h1FF});
    draw_cyc.delete();
    run_scan("two_busy", 110, 20, 1, cyc);
    check("two_busy_cycles_lit", cyc, 822);
    check("two_draw_count", draw_cyc.size(), 2);
    if (draw_cyc.size() == 2) check("two_draw_gap", draw_cyc[1] - draw_cyc[0] > 21, 1);

    // Draw unit busy from outside: request held in ISSUE with stable outputs
    clear_table();
    mem[0] = 16'h8064; mem[1] = 16'h0123; mem[2] = 16'h3050;
    mem[4] = 16'h8064; mem[5] = 16'h0456; mem[6] = 16'h9111;
    vrender = 9'd107; busy_len = 0;
    exp_q.delete();
    void'(model_scan(107));
    force_busy = 1'b1;
    start_line(sd, ta);
    repeat (25) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_no_draw", req.draw, 0);
      if (exp_q.size() > 0)
        check("hold_outs", {req.tile_id, req.veff, req.hflip, req.tile_pal, req.hpos}, exp_q[0]);
    end
    force_busy = 1'b0;
    wait_done("hold", 5000, cyc);
    check("hold_left", exp_q.size(), 0);

    // Empty table, and restart mid-scan
    clear_table();
    run_scan("empty", 50, 0, 1, cyc);
    check("empty_768", cyc, 768);
    start_line(sd, ta);
    repeat (299) @(posedge clk);
    #1;
    check("restart_pre_done", scan_done, 0);
    start_line(sd, ta);
    check("restart_addr", ta, 0);
    check("restart_done_low", sd, 0);
    wait_done("restart", 2000, cyc);
    check("restart_768", cyc, 768);

    // line_start on the draw cycle: draw stands, next ISSUE waits for busy
    mem[0] = 16'h8064; mem[1] = 16'h0123; mem[2] = 16'h3050;
    chk_stable = 1'b0;
    vrender = 9'd107; busy_len = 20;
    exp_q.delete();
    void'(model_scan(107));
    d0 = draws;
    start_line(sd, ta);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req.draw) begin
        seen = 1'b1;
        break;
      end
    end
    check("inflight_first_draw", seen, 1);
    #1;
    exp_q.delete();
    void'(model_scan(107));
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    wait_done("inflight", 5000, cyc);
    check("inflight_left", exp_q.size(), 0);
    check("inflight_draws", draws - d0, 2);

    // Asynchronous reset in the middle of a scan
    exp_q.delete();
    void'(model_scan(107));
    start_line(sd, ta);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", tbl_addr, 0);
    check("mid_rst_draw", req.draw, 0);
    check("mid_rst_done", scan_done, 1);
    check("mid_rst_outs", {req.tile_id, req.veff, req.hflip, req.tile_pal, req.hpos}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk_stable = 1'b1;

    // Randomized tables
    for (int t = 0; t < 6; t++) begin
      vr = int'($urandom_range(0, 511));
      for (int o = 0; o < OBJN; o++) begin
        logic [8:0] y;
        y = 9'(vr - int'($urandom_range(0, 140)));
        mem[o*4]   = {($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                      2'($urandom), 2'($urandom), y};
        mem[o*4+1] = 16'($urandom);
        mem[o*4+2] = 16'($urandom);
        mem[o*4+3] = 16'($urandom);
      end
      run_scan("rand", vr, int'($urandom_range(0, 4)), 1, cyc);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
